// File: rtl/shift2d_scan_ctrl.sv
// Raster scan sequencer for a shift2D KxK window: issues line-store column reads,
// aligns the x-shift enable to returned data and flags each completed window.
module shift2d_scan_ctrl #(
    parameter int pX_Y_SIZES = 3,
    parameter int pIMG_W     = 28,
    parameter int pIMG_H     = 28,
    parameter int pCOORD_W   = 8
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                istart,
    input  logic                iwin_ready,
    output logic                obusy,
    output logic                odone,
    output logic                ord_en,
    output logic [pCOORD_W-1:0] ord_row,
    output logic [pCOORD_W-1:0] ord_col,
    output logic                ox_data_en,
    output logic                oy_data_en,
    output logic                owin_valid,
    output logic [pCOORD_W-1:0] owin_x,
    output logic [pCOORD_W-1:0] owin_y
);

    // state   | meaning
    // S_IDLE  | waiting for istart
    // S_SCAN  | issuing column reads band by band
    // S_DRAIN | last read in flight, waiting for its window
    // S_DONE  | one-cycle odone pulse
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [pCOORD_W-1:0] LP_COL_LAST = pCOORD_W'(pIMG_W - 1);
    localparam logic [pCOORD_W-1:0] LP_ROW_LAST = pCOORD_W'(pIMG_H - pX_Y_SIZES);
    localparam logic [pCOORD_W-1:0] LP_PRIME    = pCOORD_W'(pX_Y_SIZES - 1);

    state_t              r_state, w_state_nxt;
    logic [pCOORD_W-1:0] r_row, r_col;
    logic                r_t1_iss, r_t1_win, r_t2_win;
    logic [pCOORD_W-1:0] r_t1_x, r_t1_y, r_t2_x, r_t2_y;
    logic                w_rd, w_col_last, w_last_rd, w_win;

    assign w_rd       = (r_state == S_SCAN) && iwin_ready;
    assign w_col_last = (r_col == LP_COL_LAST);
    assign w_last_rd  = w_rd && w_col_last && (r_row == LP_ROW_LAST);
    // The first K-1 columns of a band only prime the window.
    assign w_win      = w_rd && (r_col >= LP_PRIME);

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (istart) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_t2_win && !r_t1_iss) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_IDLE && istart) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_rd) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_last_rd ? '0 : r_row + pCOORD_W'(1);
            end else begin
                r_col <= r_col + pCOORD_W'(1);
            end
        end
    end

    // Two-stage tag pipe: stage 1 meets the returned column, stage 2 marks the full window.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_t1_iss <= 1'b0;
            r_t1_win <= 1'b0;
            r_t1_x   <= '0;
            r_t1_y   <= '0;
            r_t2_win <= 1'b0;
            r_t2_x   <= '0;
            r_t2_y   <= '0;
        end else begin
            r_t1_iss <= w_rd;
            r_t1_win <= w_win;
            r_t1_x   <= w_win ? (r_col - LP_PRIME) : '0;
            r_t1_y   <= w_win ? r_row : '0;
            r_t2_win <= r_t1_win;
            r_t2_x   <= r_t1_x;
            r_t2_y   <= r_t1_y;
        end
    end

    assign obusy      = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign odone      = (r_state == S_DONE);
    assign ord_en     = w_rd;
    assign ord_row    = r_row;
    assign ord_col    = r_col;
    assign ox_data_en = r_t1_iss;
    assign oy_data_en = 1'b0;
    assign owin_valid = r_t2_win;
    assign owin_x     = r_t2_x;
    assign owin_y     = r_t2_y;

endmodule

// File: tb/tb_shift2d_scan_ctrl.sv
// Self-checking bench: 5x5/K=3 instance against a read-numbering model, plus a
// 3x3/K=3 edge instance checked with literal timings.
module tb_shift2d_scan_ctrl;
    localparam int K = 3, W = 5, H = 5, CW = 8;
    localparam int READS = (H - K + 1) * W;
    localparam int NCYC = 4096;
    localparam int NOBS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st, rdy;
    logic obusy, odone, ord_en, ox_data_en, oy_data_en, owin_valid;
    logic [CW-1:0] ord_row, ord_col, owin_x, owin_y;

    logic rst2, st2, rdy2;
    logic obusy2, odone2, ord_en2, ox2, oy2, owin_valid2;
    logic [CW-1:0] ord_row2, ord_col2, owin_x2, owin_y2;

    shift2d_scan_ctrl #(.pX_Y_SIZES(K), .pIMG_W(W), .pIMG_H(H), .pCOORD_W(CW)) dut (
        .iclk(clk), .irst(rst), .istart(st), .iwin_ready(rdy),
        .obusy(obusy), .odone(odone), .ord_en(ord_en), .ord_row(ord_row), .ord_col(ord_col),
        .ox_data_en(ox_data_en), .oy_data_en(oy_data_en), .owin_valid(owin_valid),
        .owin_x(owin_x), .owin_y(owin_y));

    shift2d_scan_ctrl #(.pX_Y_SIZES(3), .pIMG_W(3), .pIMG_H(3), .pCOORD_W(CW)) dut_edge (
        .iclk(clk), .irst(rst2), .istart(st2), .iwin_ready(rdy2),
        .obusy(obusy2), .odone(odone2), .ord_en(ord_en2), .ord_row(ord_row2), .ord_col(ord_col2),
        .ox_data_en(ox2), .oy_data_en(oy2), .owin_valid(owin_valid2),
        .owin_x(owin_x2), .owin_y(owin_y2));

    // model state: reads are numbered n = row*W + col; fixed latencies to outputs
    bit m_act;
    int m_n, m_done_at;
    bit e_xen[NCYC];
    bit e_win[NCYC];
    int e_x[NCYC];
    int e_y[NCYC];

    int g, rc, n_vec, n_err;
    bit o_en[NOBS], o_win[NOBS], o_done[NOBS], o_zero[NOBS];
    int o_x[NOBS], o_y[NOBS], o_row[NOBS], o_col[NOBS];
    bit q_en[NOBS], q_win[NOBS], q_done[NOBS], q_zero[NOBS];
    int q_x[NOBS], q_y[NOBS];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d, rel %0d): got %0d expected %0d", nm, g, rc, act, exp);
        end
    endtask

    task automatic begin_scn();
        rc = 0;
        for (int i = 0; i < NOBS; i++) begin
            o_en[i] = 0; o_win[i] = 0; o_done[i] = 0; o_zero[i] = 0;
            o_x[i] = 0; o_y[i] = 0; o_row[i] = 0; o_col[i] = 0;
            q_en[i] = 0; q_win[i] = 0; q_done[i] = 0; q_zero[i] = 0;
            q_x[i] = 0; q_y[i] = 0;
        end
    endtask

    function automatic int cnt(input int which, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi && i < NOBS; i++) begin
            case (which)
                0: c += int'(o_en[i]);
                1: c += int'(o_win[i]);
                2: c += int'(o_done[i]);
                3: c += int'(q_en[i]);
                4: c += int'(q_win[i]);
                default: c += int'(q_done[i]);
            endcase
        end
        return c;
    endfunction

    task automatic step(input logic s, input logic r, input logic rs, input logic s2, input logic rs2);
        bit exp_busy, exp_done, exp_rd;
        int col;
        st = s; rdy = r; rst = rs; st2 = s2; rst2 = rs2;
        @(negedge clk);
        exp_busy = m_act && (m_done_at < 0 || g < m_done_at);
        exp_done = m_act && (g == m_done_at);
        exp_rd   = m_act && (m_n < READS) && r;
        n_vec++;
        cmp("obusy", obusy, exp_busy);
        cmp("odone", odone, exp_done);
        cmp("ord_en", ord_en, exp_rd);
        if (exp_rd) begin
            cmp("ord_row", ord_row, m_n / W);
            cmp("ord_col", ord_col, m_n % W);
        end
        cmp("ox_data_en", ox_data_en, e_xen[g]);
        cmp("oy_data_en", oy_data_en, 0);
        cmp("owin_valid", owin_valid, e_win[g]);
        if (e_win[g]) begin
            cmp("owin_x", owin_x, e_x[g]);
            cmp("owin_y", owin_y, e_y[g]);
        end
        if (rc < NOBS) begin
            o_en[rc] = ord_en; o_win[rc] = owin_valid; o_done[rc] = odone;
            o_x[rc] = int'(owin_x); o_y[rc] = int'(owin_y);
            o_row[rc] = int'(ord_row); o_col[rc] = int'(ord_col);
            o_zero[rc] = !(obusy | odone | ord_en | ox_data_en | oy_data_en | owin_valid)
                         && ord_row == 0 && ord_col == 0 && owin_x == 0 && owin_y == 0;
            q_en[rc] = ord_en2; q_win[rc] = owin_valid2; q_done[rc] = odone2;
            q_x[rc] = int'(owin_x2); q_y[rc] = int'(owin_y2);
            q_zero[rc] = !(obusy2 | odone2 | ord_en2 | ox2 | oy2 | owin_valid2)
                         && ord_row2 == 0 && ord_col2 == 0 && owin_x2 == 0 && owin_y2 == 0;
        end
        if (rs) begin
            m_act = 0; m_n = 0; m_done_at = -1;
            for (int i = 1; i <= 3; i++) begin
                e_xen[g+i] = 0; e_win[g+i] = 0;
            end
        end else begin
            if (exp_rd) begin
                col = m_n % W;
                e_xen[g+1] = 1;
                if (col >= K - 1) begin
                    e_win[g+2] = 1;
                    e_x[g+2] = col - K + 1;
                    e_y[g+2] = m_n / W;
                end
                m_n++;
                if (m_n == READS) m_done_at = g + 3;
            end
            if (exp_done) begin
                m_act = 0; m_n = 0; m_done_at = -1;
            end else if (!m_act && s) begin
                m_act = 1;
            end
        end
        @(posedge clk);
        #1;
        g++;
        rc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    initial begin
        g = 0; rc = 0; n_vec = 0; n_err = 0;
        m_act = 0; m_n = 0; m_done_at = -1;
        st = 0; rdy = 1; rst = 1; st2 = 0; rdy2 = 1; rst2 = 1;
        @(posedge clk); #1;
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);

        begin_scn();
        step(0, 1, 0, 0, 0);
        cmp("reset_zero", o_zero[0], 1);
        cmp("reset_zero_edge", q_zero[0], 1);
        idle(2);

        // nominal frame, both instances started together
        begin_scn();
        step(1, 1, 0, 1, 0);
        for (int i = 1; i < 22; i++) step(0, 1, 0, 0, 0);
        cmp("A_reads", cnt(0, 0, 21), 15);
        cmp("A_first_read", o_en[1], 1);
        cmp("A_last_read", o_en[15], 1);
        cmp("A_no_read16", o_en[16], 0);
        cmp("A_win5", o_win[5], 1);
        cmp("A_win7", o_win[7], 1);
        cmp("A_gap8_9", cnt(1, 8, 9), 0);
        cmp("A_win10", o_win[10], 1);
        cmp("A_win17", o_win[17], 1);
        cmp("A_wins", cnt(1, 0, 21), 9);
        cmp("A_x5", o_x[5], 0);
        cmp("A_y17", o_y[17], 2);
        cmp("A_x17", o_x[17], 2);
        cmp("A_done18", o_done[18], 1);
        cmp("A_dones", cnt(2, 0, 21), 1);
        cmp("A_row5", o_row[5], 0);
        cmp("A_col5", o_col[5], 4);
        cmp("A_row6", o_row[6], 1);
        cmp("A_col6", o_col[6], 0);
        cmp("E_reads", cnt(3, 0, 21), 3);
        cmp("E_reads1_3", cnt(3, 1, 3), 3);
        cmp("E_win5", q_win[5], 1);
        cmp("E_wins", cnt(4, 0, 21), 1);
        cmp("E_xy5", q_x[5] + q_y[5], 0);
        cmp("E_done6", q_done[6], 1);
        cmp("E_dones", cnt(5, 0, 21), 1);
        idle(2);

        // stall in cycles 4-6
        begin_scn();
        step(1, 1, 0, 0, 0);
        for (int i = 1; i < 24; i++) step(0, !(i >= 4 && i <= 6), 0, 0, 0);
        cmp("B_stall_reads", cnt(0, 4, 6), 0);
        cmp("B_resume", o_en[7], 1);
        cmp("B_resume_col", o_col[7], 3);
        cmp("B_win5", o_win[5], 1);
        cmp("B_x5", o_x[5], 0);
        cmp("B_gap6_8", cnt(1, 6, 8), 0);
        cmp("B_win9", o_win[9], 1);
        cmp("B_x9", o_x[9], 1);
        cmp("B_wins", cnt(1, 0, 23), 9);
        cmp("B_done21", o_done[21], 1);
        idle(2);

        // istart while busy
        begin_scn();
        step(1, 1, 0, 0, 0);
        for (int i = 1; i < 24; i++) step(i == 8, 1, 0, 0, 0);
        cmp("C_wins", cnt(1, 0, 23), 9);
        cmp("C_done18", o_done[18], 1);
        cmp("C_dones", cnt(2, 0, 23), 1);
        idle(2);

        // reset mid-scan, then restart
        begin_scn();
        step(1, 1, 0, 0, 0);
        for (int i = 1; i < 32; i++) step(i == 10, 1, i == 7, 0, 0);
        cmp("D_zero8", o_zero[8], 1);
        cmp("D_nowin8_14", cnt(1, 8, 14), 0);
        cmp("D_win15", o_win[15], 1);
        cmp("D_xy15", o_x[15] + o_y[15], 0);
        cmp("D_wins", cnt(1, 8, 31), 9);
        cmp("D_done28", o_done[28], 1);
        idle(2);

        // randomized ready, start and occasional reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0, 0, 0);
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
